instr_fetch: RTL and testbench

- Fetch stage of the single-cycle CPU. It sits directly upstream of main_control and ALU_control.
- Holds the PC and requests instruction words from instruction memory over a req/ack handshake that tolerates wait states.
- Latches each word into an instruction register and presents the decoded fields (OP, funct, rs, rt, rd, imm16) to the control and datapath.
- Computes the next PC from the branch, zero and jump signals when the datapath accepts the current instruction.

---
 rtl/cpu_defs.sv | 21 ++
 rtl/next_pc.sv | 29 ++
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Definitions shared by the fetch stage, main_control and ALU_control:
// opcodes, the fetch state encoding and the default reset vector.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_HOLD = 2'd2,
    FS_ERR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
// All arithmetic wraps modulo 2^32.
module next_pc (
  input  logic [31:0] pc,
  input  logic [25:0] instrIdx,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pcPlus4,
  output logic [31:0] nextPC
);

  logic [15:0] imm16;
  logic [31:0] br_off;

  assign imm16   = instrIdx[15:0];
  assign br_off  = {{14{imm16[15]}}, imm16, 2'b00};
  assign pcPlus4 = pc + 32'd4;

  always_comb begin
    nextPC = pcPlus4;
    if (jump) begin
      nextPC = {pcPlus4[31:28], instrIdx, 2'b00};
    end else if (branch && zero) begin
      nextPC = pcPlus4 + br_off;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over a req/ack handshake with optional
// timeout, and holds the instruction register until execute accepts it.
module instr_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic        instValid,
  input  logic        instAccept,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [5:0]  OP,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        fetchErr
);

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   next_pc_w;

  next_pc u_next_pc (
    .pc       (pc_q),
    .instrIdx (ir_q[25:0]),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .pcPlus4  (pcPlus4),
    .nextPC   (next_pc_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ: begin
        if (imemAck) begin
          ir_d    = imemData;
          cnt_d   = '0;
          state_d = FS_HOLD;
        end else if (TIMEOUT != 0) begin
          // The cycle that would wrap the counter is the last one allowed.
          if (cnt_q == CNT_LAST) begin
            state_d = FS_ERR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FS_HOLD: begin
        if (instAccept) begin
          pc_d    = next_pc_w;
          state_d = FS_REQ;
        end
      end
      FS_ERR:  state_d = FS_ERR;
      default: state_d = FS_IDLE;
    endcase
  end

  assign imemReq   = (state_q == FS_REQ);
  assign instValid = (state_q == FS_HOLD);
  assign fetchErr  = (state_q == FS_ERR);
  assign imemAddr  = pc_q;
  assign pc        = pc_q;

  assign OP    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign imm16 = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected fetch addresses
// and instruction records, an independent monitor pops and compares them.
module tb_instr_fetch;
  import cpu_defs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imemReq, imemAck, instValid, instAccept, branch, zero, jump, fetchErr;
  logic [31:0] imemAddr, imemData, pc, pcPlus4;
  logic [5:0]  OP, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  // second instance: high reset vector, timeout disabled
  logic        b_imemReq, b_imemAck, b_instValid, b_instAccept, b_branch, b_zero, b_jump, b_fetchErr;
  logic [31:0] b_imemAddr, b_imemData, b_pc, b_pcPlus4;
  logic [5:0]  b_OP, b_funct;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [15:0] b_imm16;

  instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck),
    .imemData(imemData), .instValid(instValid), .instAccept(instAccept), .branch(branch),
    .zero(zero), .jump(jump), .OP(OP), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
    .imm16(imm16), .pc(pc), .pcPlus4(pcPlus4), .fetchErr(fetchErr)
  );

  instr_fetch #(.RESET_PC(32'h4000_0008), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .imemReq(b_imemReq), .imemAddr(b_imemAddr), .imemAck(b_imemAck),
    .imemData(b_imemData), .instValid(b_instValid), .instAccept(b_instAccept), .branch(b_branch),
    .zero(b_zero), .jump(b_jump), .OP(b_OP), .rs(b_rs), .rt(b_rt), .rd(b_rd), .funct(b_funct),
    .imm16(b_imm16), .pc(b_pc), .pcPlus4(b_pcPlus4), .fetchErr(b_fetchErr)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } inst_t;

  inst_t       exp_inst_q[$];
  logic [31:0] exp_addr_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_pc;
  logic [31:0] model_ir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] cur_addr = 32'h0;
  inst_t       cur = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_req   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (imemReq && !prev_req) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          cur_addr = exp_addr_q.pop_front();
          chk("fetch_addr", imemAddr, cur_addr);
        end
      end else if (imemReq) begin
        chk("addr_stable", imemAddr, cur_addr);
      end
      if (instValid && !prev_valid) begin
        if (exp_inst_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          cur = exp_inst_q.pop_front();
        end
      end
      if (instValid) begin
        chk("pc", pc, cur.pc);
        chk("pcPlus4", pcPlus4, cur.pc + 32'd4);
        chk("OP", 32'(OP), 32'(cur.word[31:26]));
        chk("rs", 32'(rs), 32'(cur.word[25:21]));
        chk("rt", 32'(rt), 32'(cur.word[20:16]));
        chk("rd", 32'(rd), 32'(cur.word[15:11]));
        chk("funct", 32'(funct), 32'(cur.word[5:0]));
        chk("imm16", 32'(imm16), 32'(cur.word[15:0]));
      end
      chk("req_valid_exclusive", 32'(imemReq & instValid), 32'd0);
      prev_req   = imemReq;
      prev_valid = instValid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset(input bit late_ack);
    rst = 1'b1;
    imemAck = 1'b0;
    instAccept = 1'b0;
    #1;
    chk("async_req_drop", 32'(imemReq), 32'd0);
    chk("async_err_clear", 32'(fetchErr), 32'd0);
    @(negedge clk);
    chk("rst_valid", 32'(instValid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", {OP, rs, rt, imm16}, 32'h0);
    exp_inst_q.delete();
    exp_addr_q.delete();
    model_pc = 32'h0;
    model_ir = 32'h0;
    exp_addr_q.push_back(32'h0);
    rst = 1'b0;
    if (late_ack) begin
      imemAck  = 1'b1;
      imemData = $urandom;
    end
    @(negedge clk);
    imemAck = 1'b0;
    chk("req_after_reset", 32'(imemReq), 32'd1);
    chk("no_valid_after_reset", 32'(instValid), 32'd0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imemReq && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(imemReq), 32'd1);
  endtask

  task automatic fetch(input logic [31:0] word, input int waits);
    wait_req();
    for (int i = 0; i < waits; i++) begin
      imemAck    = 1'b0;
      imemData   = $urandom;
      instAccept = 1'($urandom);
      @(negedge clk);
      chk("req_held", 32'(imemReq), 32'd1);
    end
    imemAck    = 1'b1;
    imemData   = word;
    instAccept = 1'b0;
    exp_inst_q.push_back('{pc: model_pc, word: word});
    model_ir = word;
    @(negedge clk);
    imemAck  = 1'b0;
    imemData = $urandom;
    chk("valid_after_ack", 32'(instValid), 32'd1);
  endtask

  task automatic accept(input logic b, input logic z, input logic j, input int dly);
    logic [31:0] p4;
    logic [31:0] npc;
    int          off;
    for (int i = 0; i < dly; i++) begin
      imemAck  = 1'($urandom);
      imemData = $urandom;
      branch   = 1'($urandom);
      zero     = 1'($urandom);
      jump     = 1'($urandom);
      @(negedge clk);
      chk("valid_hold", 32'(instValid), 32'd1);
    end
    imemAck    = 1'b0;
    branch     = b;
    zero       = z;
    jump       = j;
    instAccept = 1'b1;
    p4  = model_pc + 32'd4;
    off = $signed(model_ir[15:0]);
    if (j)           npc = (p4 & 32'hF000_0000) | ({6'b0, model_ir[25:0]} * 32'd4);
    else if (b && z) npc = p4 + 32'(off * 4);
    else             npc = p4;
    model_pc = npc;
    exp_addr_q.push_back(npc);
    @(negedge clk);
    instAccept = 1'b0;
    branch     = 1'($urandom);
    zero       = 1'($urandom);
    jump       = 1'($urandom);
    chk("req_after_accept", 32'(imemReq), 32'd1);
  endtask

  localparam logic [31:0] W_ADD    = 32'h0000_0020;
  localparam logic [31:0] W_J4     = {OP_J, 26'h4};
  localparam logic [31:0] W_J0     = {OP_J, 26'h0};
  localparam logic [31:0] W_BEQ_M2 = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};

  initial begin
    int n;
    rst = 1'b1;
    imemAck = 1'b0; imemData = '0; instAccept = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0;
    b_imemAck = 1'b0; b_imemData = '0; b_instAccept = 1'b0;
    b_branch = 1'b0; b_zero = 1'b0; b_jump = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // first instruction, zero wait states
    fetch(W_ADD, 0);
    chk("add_op", 32'(OP), 32'h0);
    chk("add_funct", 32'(funct), 32'h20);
    accept(1'b0, 1'b0, 1'b0, 0);
    fetch(W_J4, 1);
    accept(1'b0, 1'b0, 1'b1, 0);
    fetch(W_BEQ_M2, 0);
    accept(1'b1, 1'b1, 1'b0, 1);
    chk("beq_taken_addr", imemAddr, 32'h0000_000C);
    fetch(W_J4, 0);
    accept(1'b0, 1'b0, 1'b1, 0);
    fetch(W_BEQ_M2, 3);
    accept(1'b1, 1'b0, 1'b0, 0);
    chk("beq_not_taken_addr", imemAddr, 32'h0000_0014);

    // wrap below zero and back through 32'hFFFF_FFFC + 4
    fetch(W_J0, 2);
    accept(1'b0, 1'b0, 1'b1, 0);
    fetch(W_BEQ_M2, 0);
    accept(1'b1, 1'b1, 1'b0, 0);
    chk("wrap_down_addr", imemAddr, 32'hFFFF_FFFC);
    fetch(W_ADD, 1);
    accept(1'b0, 1'b0, 1'b0, 0);
    chk("wrap_up_addr", imemAddr, 32'h0000_0000);

    // timeout: no ack at all
    wait_req();
    n = 0;
    while (imemReq && n < 40) begin
      imemAck = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd16);
    chk("fetch_err", 32'(fetchErr), 32'd1);
    instAccept = 1'b1;
    repeat (3) @(negedge clk);
    instAccept = 1'b0;
    chk("err_sticky", 32'(fetchErr), 32'd1);
    chk("err_no_req", 32'(imemReq), 32'd0);
    chk("err_no_valid", 32'(instValid), 32'd0);
    do_reset(1'b0);
    fetch(W_ADD, 0);
    accept(1'b0, 1'b0, 1'b0, 0);

    // reset during a wait state, then a late ack right after release
    wait_req();
    imemAck = 1'b0;
    repeat (2) @(negedge clk);
    do_reset(1'b1);
    chk("restart_addr", imemAddr, 32'h0);
    fetch(W_ADD, 0);
    accept(1'b0, 1'b0, 1'b0, 0);

    // randomized traffic
    for (int k = 0; k < 120; k++) begin
      fetch($urandom, int'($urandom_range(0, 3)));
      accept(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // second instance: jump beats branch at a high address, no timeout
    repeat (20) @(negedge clk);
    chk("b_no_timeout", 32'(b_fetchErr), 32'd0);
    chk("b_req", 32'(b_imemReq), 32'd1);
    chk("b_reset_addr", b_imemAddr, 32'h4000_0008);
    b_imemAck  = 1'b1;
    b_imemData = {OP_J, 26'h0000100};
    @(negedge clk);
    b_imemAck = 1'b0;
    chk("b_valid", 32'(b_instValid), 32'd1);
    b_branch = 1'b1; b_zero = 1'b1; b_jump = 1'b1; b_instAccept = 1'b1;
    @(negedge clk);
    b_instAccept = 1'b0;
    chk("b_req_after_accept", 32'(b_imemReq), 32'd1);
    chk("b_jump_wins_addr", b_imemAddr, 32'h4000_0400);

    repeat (2) @(negedge clk);
    chk("pending_inst_empty", 32'(exp_inst_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
